// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl
// Burst sequencer that owns both ports of the single-clock weight/activation
// memory. A LOAD burst writes words from an upstream valid/ready stream to
// consecutive addresses. A STREAM burst reads consecutive addresses and hands
// the words to the downstream MAC datapath through a registered valid/ready
// output stage. Only one burst runs at a time.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   load_start          pulse: start a LOAD burst (wins over stream_start)
//   stream_start        pulse: start a STREAM burst
//   base_addr, count    burst start address and length, sampled on start
//   s_valid/s_ready/s_data          upstream load stream
//   mem_write_en/addr/data          memory write port (combinational)
//   mem_read_addr/mem_read_data     memory read port (combinational read)
//   m_valid/m_ready/m_data/m_last   registered downstream stream
//   busy                a burst is in progress (LOAD, STREAM or FINISH)
//   done                one-cycle pulse when a burst completes
module mem_seq_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  stream_start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_ONE   = (ADDR_WIDTH+1)'(1);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_idx;     // write index in LOAD, read index in STREAM
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_m_last;

  logic [ADDR_WIDTH:0]   w_len_clamped;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_idx_last;
  logic                  w_out_fire;
  logic                  w_out_load;

  assign w_len_clamped = (count > LP_DEPTH) ? LP_DEPTH : count;
  // DEPTH is a power of two, so dropping the carry gives the modulo wrap.
  assign w_addr        = r_base + r_idx[ADDR_WIDTH-1:0];
  assign w_idx_last    = (r_idx == (r_len - LP_ONE));
  assign w_out_fire    = r_m_valid && m_ready;
  // Refill the output register when it is empty or being drained this cycle.
  assign w_out_load    = (r_state == STREAM) && (!r_m_valid || m_ready) &&
                         (r_idx < r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (load_start || stream_start) begin
            r_base <= base_addr;
            r_len  <= w_len_clamped;
            r_idx  <= '0;
          end
        end
        LOAD: begin
          if (s_valid) begin
            r_idx <= r_idx + LP_ONE;
          end
        end
        STREAM: begin
          if (w_out_load) begin
            r_m_data  <= mem_read_data;
            r_m_valid <= 1'b1;
            r_m_last  <= w_idx_last;
            r_idx     <= r_idx + LP_ONE;
          end else if (w_out_fire) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
          end
        end
        default: begin
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_state_next   = r_state;
    s_ready        = 1'b0;
    mem_write_en   = 1'b0;
    mem_write_addr = '0;
    mem_write_data = '0;
    mem_read_addr  = '0;
    busy           = 1'b1;
    done           = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (load_start) begin
          w_state_next = (w_len_clamped == '0) ? FINISH : LOAD;
        end else if (stream_start) begin
          w_state_next = (w_len_clamped == '0) ? FINISH : STREAM;
        end
      end
      LOAD: begin
        s_ready        = 1'b1;
        mem_write_en   = s_valid;
        mem_write_addr = w_addr;
        mem_write_data = s_data;
        if (s_valid && w_idx_last) begin
          w_state_next = FINISH;
        end
      end
      STREAM: begin
        mem_read_addr = w_addr;
        if (w_out_fire && r_m_last) begin
          w_state_next = FINISH;
        end
      end
      default: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Testbench for mem_seq_ctrl: a behavioural memory sits on the DUT's memory
// ports; a table of bursts is applied, expected writes and output words are
// queued when stimulus is driven and compared by a monitor as they appear.
module tb_mem_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        stream_start;
  logic [3:0]  base_addr;
  logic [4:0]  count;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        mem_write_en;
  logic [3:0]  mem_write_addr;
  logic [15:0] mem_write_data;
  logic [3:0]  mem_read_addr;
  logic [15:0] mem_read_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  mem_seq_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .stream_start(stream_start),
    .base_addr(base_addr), .count(count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: synchronous write, combinational read.
  logic [15:0] tb_mem [16];
  always @(posedge clk) begin
    if (mem_write_en) tb_mem[mem_write_addr] <= mem_write_data;
  end
  assign mem_read_data = tb_mem[mem_read_addr];

  // Reference contents, updated only from the words the bench drives.
  logic [15:0] exp_mem [16];

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;
  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } rd_t;

  wr_t wr_q[$];
  rd_t rd_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: compare writes and output handshakes against the queues.
  logic        prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_write_en) begin
        if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("write_addr", 32'(mem_write_addr), 32'(w.addr));
          chk("write_data", 32'(mem_write_data), 32'(w.data));
        end
      end
      if (prev_stall)
        chk("stall_hold", {15'd0, m_valid, m_last, m_data}, {15'd0, 1'b1, prev_last, prev_data});
      if (m_valid && rd_q.size() == 0) chk("spurious_m_valid", 32'd1, 32'd0);
      else if (m_valid && m_ready) begin
        rd_t r;
        r = rd_q.pop_front();
        chk("m_data", 32'(m_data), 32'(r.data));
        chk("m_last", 32'(m_last), 32'(r.last));
      end
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_last  <= m_last;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  typedef struct {
    bit          op_load;
    bit          both;        // raise stream_start together with load_start
    bit          mid_stream;  // pulse stream_start during the LOAD burst
    logic [3:0]  base;
    logic [4:0]  count;
    logic [15:0] d0;
    logic [15:0] dstep;
    int          mode;        // 0: m_ready high, 1: pattern 1,0,0,1
    int          exp_len;     // expected words moved
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    bit got_done;
    bit prev_hs;
    @(posedge clk); #1;
    base_addr    = v.base;
    count        = v.count;
    load_start   = v.op_load;
    stream_start = v.op_load ? v.both : 1'b1;
    if (!v.op_load) begin
      for (int i = 0; i < v.exp_len; i++) begin
        logic [3:0] a;
        a = v.base + 4'(i);
        rd_q.push_back('{data: exp_mem[a], last: (i == v.exp_len - 1)});
      end
    end
    @(posedge clk); #1;
    load_start   = 1'b0;
    stream_start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    if (v.op_load) begin
      for (int i = 0; i < v.exp_len; i++) begin
        logic [3:0]  a;
        logic [15:0] d;
        a = v.base + 4'(i);
        d = v.d0 + 16'(i) * v.dstep;
        s_valid = 1'b1;
        s_data  = d;
        wr_q.push_back('{addr: a, data: d});
        exp_mem[a] = d;
        stream_start = (v.mid_stream && i == 1);
        @(posedge clk); #1;
      end
      s_valid      = 1'b0;
      stream_start = 1'b0;
      chk("load_done", 32'(done), 32'd1);
    end else begin
      got_done = 1'b0;
      prev_hs  = 1'b0;
      for (int c = 0; c < 80 && !got_done; c++) begin
        if (done || prev_hs || (c == 0 && v.exp_len == 0))
          chk("stream_done_timing", 32'(done), 32'(prev_hs || (c == 0 && v.exp_len == 0)));
        if (done) got_done = 1'b1;
        else begin
          m_ready = (v.mode == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
          if (c == 0 && v.exp_len > 0) chk("m_valid_t1", 32'(m_valid), 32'd0);
          if (c == 1 && v.exp_len > 0) chk("m_valid_t2", 32'(m_valid), 32'd1);
          prev_hs = m_valid && m_ready && m_last;
          @(posedge clk); #1;
        end
      end
      if (!got_done) chk("stream_timeout", 32'd0, 32'd1);
      m_ready = 1'b0;
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("burst %0d: %s base=%0d count=%0d words=%0d checks=%0d/%0d",
             id, v.op_load ? "LOAD" : "STREAM", v.base, v.count, v.exp_len, n_pass, n_chk);
  endtask

  vec_t vecs[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 0, 0, 4'd0,  5'd4,  16'h1111, 16'h1111, 0, 4};
    vecs[1]  = '{0, 0, 0, 4'd0,  5'd4,  16'h0000, 16'h0000, 0, 4};
    vecs[2]  = '{0, 0, 0, 4'd0,  5'd4,  16'h0000, 16'h0000, 1, 4};
    vecs[3]  = '{1, 0, 0, 4'd14, 5'd4,  16'h5000, 16'h0001, 0, 4};
    vecs[4]  = '{0, 0, 0, 4'd14, 5'd4,  16'h0000, 16'h0000, 0, 4};
    vecs[5]  = '{1, 1, 1, 4'd4,  5'd3,  16'h7000, 16'h0010, 0, 3};
    vecs[6]  = '{1, 0, 0, 4'd6,  5'd0,  16'hDEAD, 16'h0000, 0, 0};
    vecs[7]  = '{0, 0, 0, 4'd6,  5'd0,  16'h0000, 16'h0000, 0, 0};
    vecs[8]  = '{1, 0, 0, 4'd3,  5'd20, 16'h9000, 16'h0003, 0, 16};
    vecs[9]  = '{0, 0, 0, 4'd3,  5'd20, 16'h0000, 16'h0000, 1, 16};
    vecs[10] = '{0, 0, 0, 4'd5,  5'd1,  16'h0000, 16'h0000, 0, 1};
    vecs[11] = '{0, 0, 0, 4'd0,  5'd2,  16'h0000, 16'h0000, 0, 2};

    for (int i = 0; i < 16; i++) begin
      tb_mem[i]  = '0;
      exp_mem[i] = '0;
    end
    rst_n = 1'b0; load_start = 1'b0; stream_start = 1'b0;
    base_addr = '0; count = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_wr_en",   32'(mem_write_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last",  32'(m_last), 32'd0);
    chk("rst_m_data",  32'(m_data), 32'd0);
    chk("rst_rd_addr", 32'(mem_read_addr), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset after two of four LOAD words: burst abandoned, no further writes.
    @(posedge clk); #1;
    base_addr = 4'd0; count = 5'd4; load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = 16'hA000 + 16'(i);
      wr_q.push_back('{addr: 4'(i), data: s_data});
      exp_mem[i] = s_data;
      @(posedge clk); #1;
    end
    rst_n  = 1'b0;
    s_data = 16'hBEEF;
    #1;
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_wr_en",   32'(mem_write_en), 32'd0);
    chk("mid_rst_busy",    32'(busy), 32'd0);
    chk("mid_rst_m_data",  32'(m_data), 32'd0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    s_valid = 1'b0;
    rst_n   = 1'b1;
    chk("mid_rst_wr_q", 32'(wr_q.size()), 32'd0);
    $display("burst 11: LOAD interrupted by reset after 2 words checks=%0d/%0d", n_pass, n_chk);
    run_vec(vecs[11], 12);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_seq_ctrl.md
# mem_seq_ctrl

Sequencer that owns both ports of the autoencoder's single-clock weight/activation memory (`mem`). It runs LOAD bursts, which take words from an upstream valid/ready stream and write them to consecutive addresses. It runs STREAM bursts, which read consecutive addresses and present them to the downstream MAC datapath on a registered valid/ready stream. Only one burst is active at a time, and bursts start from a command pulse.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: memory address width; must match `mem`.
- `DATA_WIDTH`, 16: word width.
- `DEPTH`, 16: number of words; must equal 2**ADDR_WIDTH, so addresses wrap modulo DEPTH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  pulse that starts a LOAD burst.
- `stream_start`  in  1  pulse that starts a STREAM burst.
- `base_addr`  in  ADDR_WIDTH  first address of the burst; sampled on start.
- `count`  in  ADDR_WIDTH+1  burst length in words; sampled on start.
- `s_valid`  in  1  load-stream word available.
- `s_ready`  out  1  controller accepts a load word.
- `s_data`  in  DATA_WIDTH  load-stream word.
- `mem_write_en`  out  1  to `mem` write_en.
- `mem_write_addr`  out  ADDR_WIDTH  to `mem` write_addr.
- `mem_write_data`  out  DATA_WIDTH  to `mem` write_data.
- `mem_read_addr`  out  ADDR_WIDTH  to `mem` read_addr.
- `mem_read_data`  in  DATA_WIDTH  from `mem` read_data (combinational read).
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  DATA_WIDTH  output word (registered).
- `m_last`  out  1  marks the final word of a STREAM burst.
- `busy`  out  1  a burst is active.
- `done`  out  1  one-cycle pulse when a burst completes.

## Operation
- States: IDLE, LOAD, STREAM, FINISH.
- **IDLE**
  - On `load_start`: latch `base_addr` and `count`, clear the index, go to LOAD.
  - Else on `stream_start`: same latch, go to STREAM.
  - If both start pulses are high in the same cycle, LOAD wins.
  - Effective length: `count` values above DEPTH clamp to DEPTH.
  - `count`=0: go directly to FINISH; no memory access.
- Start pulses are ignored while `busy`=1.
- **LOAD**
  - `s_ready`=1 throughout.
  - Combinational write signals: `mem_write_en`=`s_valid`, `mem_write_addr`=(base+idx) mod DEPTH, `mem_write_data`=`s_data`.
  - idx increments on each `s_valid`&&`s_ready`.
  - On the handshake of word len-1, go to FINISH.
- **STREAM**
  - `mem_read_addr`=(base+rd_idx) mod DEPTH.
  - The output register loads `mem_read_data` and rd_idx increments whenever the register is empty, or `m_valid`&&`m_ready`, and rd_idx<len.
  - `m_last`=1 with the word at rd_idx=len-1.
  - The final output handshake goes to FINISH.
  - `m_valid` and `m_data` hold stable while `m_ready`=0.
- **FINISH**: `done`=1 for one cycle, then IDLE.
- `busy`=1 in LOAD, STREAM and FINISH.
- Outside LOAD: `s_ready`=0 and `mem_write_en`=0. `mem_read_addr` is 0 in IDLE.
- Wrap: with base+idx ≥ DEPTH, the address rolls over to 0 with no error.

## Timing
- Reset (asynchronous, from `rst_n` low): state=IDLE; `m_valid`, `m_last`, `m_data`, `done`, `busy`, `s_ready`, `mem_write_en`, index registers all 0.
- Reset mid-burst: the burst is abandoned and no further writes occur. Memory contents are not cleared.
- Start sampled at edge T; `busy`=1 from T+1.
- LOAD:
  - The first write can occur in cycle T+1.
  - Throughput is 1 word/cycle.
  - `done` is asserted the cycle after the final write.
- STREAM:
  - The first `m_valid` is asserted at T+2.
  - Throughput is 1 word/cycle with `m_ready` held high.
  - `done` is asserted the cycle after the `m_last` handshake.
- A new start is accepted the cycle after `done`, when the state is IDLE.

## Test plan
- LOAD with base=0, count=4 and words 0x1111..0x4444, `s_valid` held high -> writes at addr 0..3 in 4 consecutive cycles; `done` 1 cycle after the last write; `busy` low afterwards.
- STREAM with base=0, count=4, `m_ready`=1 -> `m_valid` at T+2; data 0x1111,0x2222,0x3333,0x4444 on consecutive cycles; `m_last` on 0x4444; `done` next cycle.
- STREAM with `m_ready` toggling 1,0,0,1… -> no word dropped or duplicated; `m_data` stable during stalls; order preserved.
- Wrap: LOAD with base=14, count=4 -> addresses 14,15,0,1. STREAM with the same base and count -> same order back.
- Both starts in one cycle, plus a `stream_start` during an active LOAD -> only the LOAD runs, and the mid-burst `stream_start` has no effect. `count`=0 -> `done` pulse with no `mem_write_en`. `count`=20 -> exactly 16 words.
- `rst_n` asserted after 2 of 4 LOAD words -> all outputs 0 immediately; no further writes; a subsequent STREAM returns the 2 written words at their addresses.
